// File: rtl/mult_sequencer_pkg.sv
// Shared state encoding and default sizing for the shift-add multiplier sequencer.
package mult_sequencer_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int CNT_W_DEF = 5;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/mult_sequencer_iter_counter5.sv
// Iteration counter with synchronous clear/enable; tc flags the last count (all ones).
// Single-cycle update, no backpressure; wraps naturally after terminal count.
module iter_counter5 #(
    parameter int CNT_W = 5
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= count + 1'b1;
        end
    end

    assign tc = &count;

endmodule

// File: rtl/mult_sequencer.sv
// Unsigned WIDTHxWIDTH shift-add multiplier driving the shared ALU adder; done WIDTH+1 cycles after accept.
// No backpressure: start is only sampled in IDLE and is dropped otherwise; results hold until next accept.
module mult_sequencer
    import mult_sequencer_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] product_hi,
    output logic [WIDTH-1:0] product_lo,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    input  logic [WIDTH-1:0] alu_sum,
    input  logic             alu_cout
);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] mcand, hi, lo;
    logic             load, shift, cnt_clr, cnt_en, last_iter;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        done      = 1'b0;
        alu_a     = '0;
        alu_b     = '0;
        load      = 1'b0;
        shift     = 1'b0;
        cnt_clr   = 1'b0;
        cnt_en    = 1'b0;
        case (state)
            ST_IDLE: begin
                if (start) begin
                    load      = 1'b1;
                    cnt_clr   = 1'b1;
                    state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                busy   = 1'b1;
                alu_a  = hi;
                alu_b  = lo[0] ? mcand : '0;
                shift  = 1'b1;
                cnt_en = 1'b1;
                if (last_iter) begin
                    state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                done      = 1'b1;
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // The adder carry becomes hi's MSB; losing it breaks operands >= 2**(WIDTH-1).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mcand <= '0;
            hi    <= '0;
            lo    <= '0;
        end else if (load) begin
            mcand <= a;
            hi    <= '0;
            lo    <= b;
        end else if (shift) begin
            hi <= {alu_cout, alu_sum[WIDTH-1:1]};
            lo <= {alu_sum[0], lo[WIDTH-1:1]};
        end
    end

    iter_counter5 #(.CNT_W(CNT_W)) u_iter_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .en    (cnt_en),
        .tc    (last_iter)
    );

    assign product_hi = hi;
    assign product_lo = lo;

endmodule

// File: tb/tb_mult_sequencer.sv
// Bench for mult_sequencer: models the shared ALU adder and checks results against plain 64-bit multiplication.
module tb_mult_sequencer;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] a, b;
    logic        busy, done;
    logic [31:0] product_hi, product_lo;
    logic [31:0] alu_a, alu_b, alu_sum;
    logic        alu_cout;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    // Shared combinational ALU adder.
    assign {alu_cout, alu_sum} = {1'b0, alu_a} + {1'b0, alu_b};

    mult_sequencer dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .a          (a),
        .b          (b),
        .busy       (busy),
        .done       (done),
        .product_hi (product_hi),
        .product_lo (product_lo),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_sum    (alu_sum),
        .alu_cout   (alu_cout)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic run_op(input logic [31:0] x, input logic [31:0] y,
                          input bit chk_zero_b, input int pulse_at);
        int          k;
        int          nbusy;
        bit          zb_ok;
        logic [63:0] expv;
        expv = {32'd0, x} * {32'd0, y};
        @(negedge clk);
        start = 1'b1; a = x; b = y;
        @(negedge clk);
        start = 1'b0; a = $urandom; b = $urandom;
        k = 1; nbusy = 0; zb_ok = 1'b1;
        while (!done && k < 60) begin
            if (busy) begin
                nbusy++;
                if (alu_b != 32'd0) zb_ok = 1'b0;
            end
            if (k == pulse_at) begin
                start = 1'b1; a = 32'd9; b = 32'd9;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
            k++;
        end
        start = 1'b0;
        check("done_latency", 64'(k), 64'd33);
        check("busy_cycles", 64'(nbusy), 64'd32);
        if (chk_zero_b) check("alu_b_zero_in_run", {63'd0, zb_ok}, 64'd1);
        check("product", {product_hi, product_lo}, expv);
        @(negedge clk);
        check("done_one_cycle", {63'd0, done}, 64'd0);
        check("product_hold", {product_hi, product_lo}, expv);
        check("idle_alu_a", {32'd0, alu_a}, 64'd0);
    endtask

    initial begin
        int ndone;
        int last_done;
        int cyc;
        reset = 1'b1; start = 1'b0; a = '0; b = '0;
        repeat (2) @(negedge clk);
        check("rst_busy", {63'd0, busy}, 64'd0);
        check("rst_done", {63'd0, done}, 64'd0);
        check("rst_product", {product_hi, product_lo}, 64'd0);
        check("rst_alu", {alu_a, alu_b}, 64'd0);
        reset = 1'b0;

        run_op(32'd3, 32'd5, 1'b0, -1);
        run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, -1);
        run_op(32'h1234_5678, 32'd0, 1'b1, -1);
        run_op(32'd0, 32'hDEAD_BEEF, 1'b0, -1);

        // Start pulse mid-run must be ignored and not queued.
        run_op(32'd7, 32'd6, 1'b0, 10);
        ndone = 0;
        for (int i = 0; i < 40; i++) begin
            if (done || busy) ndone++;
            @(negedge clk);
        end
        check("no_queued_start", 64'(ndone), 64'd0);

        for (int i = 0; i < 8; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            y = $urandom;
            if ($urandom_range(0, 1) == 1) x[31] = 1'b1;
            if ($urandom_range(0, 1) == 1) y[31] = 1'b1;
            run_op(x, y, 1'b0, -1);
        end

        // Asynchronous reset in RUN iteration 15.
        @(negedge clk);
        start = 1'b1; a = 32'hFFFF_FFFF; b = 32'hFFFF_FFFF;
        @(negedge clk);
        start = 1'b0;
        repeat (15) @(negedge clk);
        check("pre_reset_busy", {63'd0, busy}, 64'd1);
        #1 reset = 1'b1;
        #1;
        check("async_rst_busy", {63'd0, busy}, 64'd0);
        check("async_rst_done", {63'd0, done}, 64'd0);
        check("async_rst_product", {product_hi, product_lo}, 64'd0);
        @(negedge clk);
        reset = 1'b0;
        run_op(32'h0001_0000, 32'h0001_0000, 1'b0, -1);

        // Start held high: a done every 34 cycles.
        @(negedge clk);
        start = 1'b1; a = 32'd2; b = 32'h8000_0000;
        ndone = 0; last_done = -1; cyc = 0;
        while (ndone < 3 && cyc < 200) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                check("b2b_product", {product_hi, product_lo}, 64'h0000_0001_0000_0000);
                if (last_done >= 0) check("b2b_spacing", 64'(cyc - last_done), 64'd34);
                last_done = cyc;
                ndone++;
            end
        end
        start = 1'b0;
        check("b2b_done_count", 64'(ndone), 64'd3);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
